// File: rtl/fsk_tone_sched_if.sv
// Symbol stream and tone-table write port of the FSK tone sequencer.
//   sym_valid / sym_data / sym_ready : symbol handshake. A symbol transfers on
//                                      any cycle where valid and ready are both high.
//   tbl_we / tbl_addr / tbl_data     : tone-table write port, one write per cycle.
// master = symbol/table source, slave = fsk_tone_sched.
interface fsk_tone_sched_if;
    logic       sym_valid;
    logic [1:0] sym_data;
    logic       sym_ready;
    logic       tbl_we;
    logic [1:0] tbl_addr;
    logic [7:0] tbl_data;

    modport master (
        output sym_valid, sym_data, tbl_we, tbl_addr, tbl_data,
        input  sym_ready
    );

    modport slave (
        input  sym_valid, sym_data, tbl_we, tbl_addr, tbl_data,
        output sym_ready
    );
endinterface

// File: rtl/fsk_tone_sched.sv
// FSK tone sequencer for the 8-bit-phase quadrature NCO.
// Maps each accepted symbol to a phase increment through a 4-entry tone table.
// Holds that increment for sym_len+1 NCO sample strobes.
// Keys tx_gate in line with the NCO's three-strobe output pipeline.
//   clock, reset_n   : clock; asynchronous active-low reset
//   prescale         : one strobe every prescale+1 clocks while busy
//   sym_len          : symbol duration in strobes minus one, taken at accept
//   sif              : symbol handshake + tone-table write port (slave side)
//   nco_clk_en       : one-cycle NCO sample strobe
//   phase_increment  : registered tone for the NCO (0 when not sending)
//   tx_gate          : high while the NCO output carries symbol tone
//   busy             : sequencer not idle
//   sym_count        : accepted symbols, wraps at 16 bits
//
// state | meaning
// IDLE  | no strobes, increment 0, ready for a symbol
// RUN   | sending a symbol; ready only at the last strobe of the symbol
// DRAIN | increment 0, three more strobes flush the NCO pipeline
module fsk_tone_sched #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [7:0]            sym_len,
    fsk_tone_sched_if.slave       sif,
    output logic                  nco_clk_en,
    output logic [7:0]            phase_increment,
    output logic                  tx_gate,
    output logic                  busy,
    output logic [15:0]           sym_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [PRESCALE_W-1:0] PCNT_ONE = 1;

    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [7:0]            scnt_q, scnt_d;
    logic [1:0]            dcnt_q, dcnt_d;
    logic [7:0]            tbl_q [4];
    logic [7:0]            tbl_d [4];
    logic [7:0]            phase_q, phase_d;
    logic [2:0]            gate_q, gate_d;
    logic [15:0]           cnt_q, cnt_d;

    logic strobe;
    logic boundary;
    logic accept;

    assign busy          = (state_q != IDLE);
    assign strobe        = busy && (pcnt_q == '0);
    assign boundary      = (state_q == RUN) && strobe && (scnt_q == 8'd0);
    assign sif.sym_ready = (state_q == IDLE) || boundary;
    assign accept        = sif.sym_valid && sif.sym_ready;

    assign nco_clk_en      = strobe;
    assign phase_increment = phase_q;
    assign tx_gate         = gate_q[2];
    assign sym_count       = cnt_q;

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        scnt_d  = scnt_q;
        dcnt_d  = dcnt_q;
        tbl_d   = tbl_q;
        phase_d = phase_q;
        gate_d  = gate_q;
        cnt_d   = cnt_q;

        if (busy) begin
            pcnt_d = strobe ? prescale : (pcnt_q - PCNT_ONE);
        end

        // The gate pipeline mirrors the NCO: a 1 marks a strobe that carried tone.
        if (strobe) begin
            gate_d = {gate_q[1:0], (state_q == RUN)};
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    phase_d = tbl_q[sif.sym_data];
                    pcnt_d  = '0;
                    scnt_d  = sym_len;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (strobe) begin
                    if (scnt_q == 8'd0) begin
                        if (accept) begin
                            phase_d = tbl_q[sif.sym_data];
                            scnt_d  = sym_len;
                        end else begin
                            phase_d = 8'd0;
                            dcnt_d  = 2'd2;
                            state_d = DRAIN;
                        end
                    end else begin
                        scnt_d = scnt_q - 8'd1;
                    end
                end
            end
            DRAIN: begin
                if (strobe) begin
                    if (dcnt_q == 2'd0) begin
                        state_d = IDLE;
                        gate_d  = 3'b000;
                    end else begin
                        dcnt_d = dcnt_q - 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            cnt_d = cnt_q + 16'd1;
        end

        // Written after the accept read so a same-cycle write is not seen by it.
        if (sif.tbl_we) begin
            tbl_d[sif.tbl_addr] = sif.tbl_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pcnt_q  <= '0;
            scnt_q  <= 8'd0;
            dcnt_q  <= 2'd0;
            tbl_q   <= '{default: 8'd0};
            phase_q <= 8'd0;
            gate_q  <= 3'b000;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            scnt_q  <= scnt_d;
            dcnt_q  <= dcnt_d;
            tbl_q   <= tbl_d;
            phase_q <= phase_d;
            gate_q  <= gate_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fsk_tone_sched.sv
module tb_fsk_tone_sched;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  prescale = 8'd0;
    logic [7:0]  sym_len = 8'd0;
    logic        nco_clk_en;
    logic [7:0]  phase_increment;
    logic        tx_gate;
    logic        busy;
    logic [15:0] sym_count;

    fsk_tone_sched_if sif ();

    fsk_tone_sched #(.PRESCALE_W(8)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .prescale        (prescale),
        .sym_len         (sym_len),
        .sif             (sif),
        .nco_clk_en      (nco_clk_en),
        .phase_increment (phase_increment),
        .tx_gate         (tx_gate),
        .busy            (busy),
        .sym_count       (sym_count)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Scoreboard: each accept pushes one expected increment per strobe of the symbol.
    logic [7:0]  exp_q [$];
    logic [7:0]  tbl_m [4] = '{default: 8'd0};
    logic [2:0]  gate_m = 3'b000;
    logic [15:0] cnt_m = 16'd0;

    always @(negedge clock) begin
        if (!reset_n) begin
            exp_q.delete();
            tbl_m  = '{default: 8'd0};
            gate_m = 3'b000;
            cnt_m  = 16'd0;
        end else begin
            check("mon_tx_gate", tx_gate, gate_m[2]);
            check("mon_sym_count", sym_count, cnt_m);
            check("mon_sym_ready", sif.sym_ready,
                  !busy || (nco_clk_en && exp_q.size() == 1));
            if (nco_clk_en) begin
                if (exp_q.size() > 0) begin
                    check("mon_phase", phase_increment, exp_q.pop_front());
                    gate_m = {gate_m[1:0], 1'b1};
                end else begin
                    check("mon_phase_drain", phase_increment, 0);
                    gate_m = {gate_m[1:0], 1'b0};
                end
            end
            if (sif.sym_valid && sif.sym_ready) begin
                for (int i = 0; i <= int'(sym_len); i++) exp_q.push_back(tbl_m[sif.sym_data]);
                cnt_m = cnt_m + 16'd1;
            end
            if (sif.tbl_we) tbl_m[sif.tbl_addr] = sif.tbl_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset_n       = 1'b0;
        sif.sym_valid = 1'b0;
        sif.tbl_we    = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic write_tbl(input logic [1:0] a, input logic [7:0] d);
        @(posedge clock);
        #1;
        sif.tbl_we   = 1'b1;
        sif.tbl_addr = a;
        sif.tbl_data = d;
        @(posedge clock);
        #1;
        sif.tbl_we = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 1000; k++) begin
            @(negedge clock);
            if (!busy) break;
        end
        check("wait_idle", busy, 0);
    endtask

    // Single-symbol cycle table, row k = cycle N+k, accept at N.
    typedef struct {
        logic       valid;
        logic       exp_strobe;
        logic       exp_gate;
        logic       exp_busy;
        logic       exp_ready;
        logic       chk_phase;
        logic [7:0] exp_phase;
    } vec_t;

    vec_t vt [19];
    int   strobes, gates, busy_cyc, acc, cyc;

    initial begin
        for (int k = 0; k < 19; k++) begin
            vt[k].valid      = (k == 0);
            vt[k].exp_strobe = (k inside {1, 5, 9, 13, 17});
            vt[k].exp_gate   = (k >= 10 && k <= 17);
            vt[k].exp_busy   = (k >= 1 && k <= 17);
            vt[k].exp_ready  = (k == 0 || k == 5 || k >= 18);
            vt[k].chk_phase  = vt[k].exp_strobe || k == 0 || k == 18;
            vt[k].exp_phase  = (k == 1 || k == 5) ? 8'h10 : 8'h00;
        end
        sif.sym_valid = 1'b0;
        sif.sym_data  = 2'd0;
        sif.tbl_we    = 1'b0;
        sif.tbl_addr  = 2'd0;
        sif.tbl_data  = 8'd0;

        // Reset state
        do_reset();
        #1;
        check("rst_sym_ready", sif.sym_ready, 1);
        check("rst_nco_clk_en", nco_clk_en, 0);
        check("rst_phase", phase_increment, 0);
        check("rst_tx_gate", tx_gate, 0);
        check("rst_busy", busy, 0);
        check("rst_sym_count", sym_count, 0);

        // Single symbol, prescale 3, sym_len 1
        write_tbl(2'd1, 8'h10);
        prescale = 8'd3;
        sym_len  = 8'd1;
        for (int k = 0; k < 19; k++) begin
            @(posedge clock);
            #1;
            sif.sym_valid = vt[k].valid;
            sif.sym_data  = 2'd1;
            @(negedge clock);
            check($sformatf("single_strobe[%0d]", k), nco_clk_en, vt[k].exp_strobe);
            check($sformatf("single_gate[%0d]", k), tx_gate, vt[k].exp_gate);
            check($sformatf("single_busy[%0d]", k), busy, vt[k].exp_busy);
            check($sformatf("single_ready[%0d]", k), sif.sym_ready, vt[k].exp_ready);
            if (vt[k].chk_phase)
                check($sformatf("single_phase[%0d]", k), phase_increment, vt[k].exp_phase);
        end
        check("single_count", sym_count, 1);

        // Back-to-back symbols 0,1,2 at prescale 0, sym_len 2
        do_reset();
        write_tbl(2'd0, 8'h04);
        write_tbl(2'd1, 8'h08);
        write_tbl(2'd2, 8'h0C);
        prescale = 8'd0;
        sym_len  = 8'd2;
        strobes = 0; gates = 0; busy_cyc = 0;
        fork
            begin
                for (int s = 0; s < 3; s++) begin
                    @(posedge clock);
                    #1;
                    sif.sym_valid = 1'b1;
                    sif.sym_data  = 2'(s);
                    for (int k = 0; k < 20; k++) begin
                        @(negedge clock);
                        if (sif.sym_ready) break;
                    end
                end
                @(posedge clock);
                #1;
                sif.sym_valid = 1'b0;
            end
            begin
                repeat (40) begin
                    @(negedge clock);
                    strobes  += int'(nco_clk_en);
                    gates    += int'(tx_gate);
                    busy_cyc += int'(busy);
                end
            end
        join
        check("b2b_strobes", strobes, 12);
        check("b2b_busy_cycles", busy_cyc, 12);
        check("b2b_gate_width", gates, 9);
        check("b2b_sym_count", sym_count, 3);

        // Same-cycle table write vs accept
        do_reset();
        write_tbl(2'd2, 8'h20);
        prescale = 8'd0;
        sym_len  = 8'd0;
        @(posedge clock);
        #1;
        sif.sym_valid = 1'b1;
        sif.sym_data  = 2'd2;
        sif.tbl_we    = 1'b1;
        sif.tbl_addr  = 2'd2;
        sif.tbl_data  = 8'h55;
        @(negedge clock);
        check("hazard_accept", sif.sym_ready, 1);
        @(posedge clock);
        #1;
        sif.sym_valid = 1'b0;
        sif.tbl_we    = 1'b0;
        @(negedge clock);
        check("hazard_old_value", phase_increment, 8'h20);
        wait_idle();
        @(posedge clock);
        #1;
        sif.sym_valid = 1'b1;
        @(negedge clock);
        @(posedge clock);
        #1;
        sif.sym_valid = 1'b0;
        @(negedge clock);
        check("hazard_new_value", phase_increment, 8'h55);
        wait_idle();

        // Reset while sending
        write_tbl(2'd3, 8'h33);
        prescale = 8'd1;
        sym_len  = 8'd7;
        @(posedge clock);
        #1;
        sif.sym_valid = 1'b1;
        sif.sym_data  = 2'd3;
        @(negedge clock);
        @(posedge clock);
        #1;
        sif.sym_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (tx_gate && nco_clk_en) break;
        end
        check("run_gate_before_reset", tx_gate && nco_clk_en, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("run_rst_nco_clk_en", nco_clk_en, 0);
        check("run_rst_phase", phase_increment, 0);
        check("run_rst_tx_gate", tx_gate, 0);
        check("run_rst_busy", busy, 0);
        check("run_rst_sym_ready", sif.sym_ready, 1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        write_tbl(2'd1, 8'h21);
        prescale = 8'd2;
        sym_len  = 8'd1;
        @(posedge clock);
        #1;
        sif.sym_valid = 1'b1;
        sif.sym_data  = 2'd1;
        @(negedge clock);
        @(posedge clock);
        #1;
        sif.sym_valid = 1'b0;
        @(negedge clock);
        check("restart_first_strobe", nco_clk_en, 1);
        check("restart_phase", phase_increment, 8'h21);
        wait_idle();
        check("restart_sym_count", sym_count, 1);

        // sym_count wrap after 65536 accepts
        do_reset();
        prescale = 8'd0;
        sym_len  = 8'd0;
        @(posedge clock);
        #1;
        sif.sym_valid = 1'b1;
        sif.sym_data  = 2'd0;
        acc = 0;
        cyc = 0;
        while (acc < 65536 && cyc < 70000) begin
            @(negedge clock);
            cyc++;
            if (sif.sym_ready) acc++;
            if (acc < 65536) begin
                @(posedge clock);
                #1;
            end
        end
        check("wrap_accepts", acc, 65536);
        check("wrap_ffff", sym_count, 16'hFFFF);
        @(posedge clock);
        #1;
        sif.sym_valid = 1'b0;
        @(negedge clock);
        check("wrap_zero", sym_count, 16'h0000);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
